ibuf_fetch_queue: RTL

- Instruction buffer between the fetch unit and decode.
- Accepts fetch groups of INSTR_PER_FETCH slots, each carrying instr, pc, slot_valid and pred_npc.
- Compacts the valid slots into an in-order circular queue and presents up to DECODE_WIDTH oldest entries per cycle to decode.
- Carries pred_npc through unchanged so decode can place it in each uop.

---
 rtl/ibuf_fetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ibuf_fetch_queue.sv
// Instruction buffer between fetch and decode: compacts valid fetch slots
// into an in-order circular queue and presents the oldest entries to decode.
module ibuf_fetch_queue #(
    parameter int INSTR_PER_FETCH = 4,
    parameter int DECODE_WIDTH    = 4,
    parameter int DEPTH           = 16,
    parameter int XLEN            = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            fe_valid_i,
    output logic                            fe_ready_o,
    input  logic [INSTR_PER_FETCH-1:0]      fe_slot_valid_i,
    input  logic [INSTR_PER_FETCH*32-1:0]   fe_instr_i,
    input  logic [INSTR_PER_FETCH*XLEN-1:0] fe_pc_i,
    input  logic [INSTR_PER_FETCH*XLEN-1:0] fe_pred_npc_i,
    output logic [DECODE_WIDTH-1:0]         de_valid_o,
    input  logic                            de_ready_i,
    output logic [DECODE_WIDTH*32-1:0]      de_instr_o,
    output logic [DECODE_WIDTH*XLEN-1:0]    de_pc_o,
    output logic [DECODE_WIDTH*XLEN-1:0]    de_pred_npc_o,
    output logic [$clog2(DEPTH):0]          count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] npc_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] n_enq;
    logic [CW-1:0] n_deq;
    logic          enq_fire;
    logic          deq_fire;
    logic [PW-1:0] wr_idx [INSTR_PER_FETCH];

    assign fe_ready_o = (CW'(DEPTH) - count_q) >= CW'(INSTR_PER_FETCH);
    assign enq_fire   = fe_valid_i & fe_ready_o & ~flush_i;
    assign deq_fire   = de_ready_i & ~flush_i;
    assign count_o    = count_q;

    // Each valid slot lands at tail plus the number of valid slots below it.
    always_comb begin
        n_enq = '0;
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
            wr_idx[s] = tail_q + n_enq[PW-1:0];
            n_enq     = n_enq + CW'(fe_slot_valid_i[s]);
        end
    end

    assign n_deq = (count_q > CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                tail_d = tail_q + n_enq[PW-1:0];
            end
            if (deq_fire) begin
                head_d = head_q + n_deq[PW-1:0];
            end
            count_d = count_q + (enq_fire ? n_enq : '0)
                              - (deq_fire ? n_deq : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            for (int s = 0; s < INSTR_PER_FETCH; s++) begin
                if (fe_slot_valid_i[s]) begin
                    instr_q[wr_idx[s]] <= fe_instr_i[s*32 +: 32];
                    pc_q[wr_idx[s]]    <= fe_pc_i[s*XLEN +: XLEN];
                    npc_q[wr_idx[s]]   <= fe_pred_npc_i[s*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
        logic [PW-1:0] rd_idx;
        assign rd_idx                      = head_q + PW'(i);
        assign de_valid_o[i]               = count_q > CW'(i);
        assign de_instr_o[i*32 +: 32]      = instr_q[rd_idx];
        assign de_pc_o[i*XLEN +: XLEN]     = pc_q[rd_idx];
        assign de_pred_npc_o[i*XLEN +: XLEN] = npc_q[rd_idx];
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (
        @(posedge clk_i) disable iff (rst_i) count_q <= CW'(DEPTH));
    a_idle_no_enq : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (!fe_valid_i && !flush_i) |=> $stable(tail_q));
`endif

endmodule
